// File: rtl/pm_irq_pkg.sv
// Shared definitions for the interrupt controller: register map, source count
// and the 2-bit priority type.
package pm_irq_pkg;

    localparam int unsigned NUM_SRC = 16;
    localparam int unsigned NUM_GRP = NUM_SRC / 2;

    localparam logic [23:0] ADDR_PRIO_LO = 24'h002020;
    localparam logic [23:0] ADDR_PRIO_HI = 24'h002021;
    localparam logic [23:0] ADDR_EN_LO   = 24'h002023;
    localparam logic [23:0] ADDR_EN_HI   = 24'h002024;
    localparam logic [23:0] ADDR_PEND_LO = 24'h002027;
    localparam logic [23:0] ADDR_PEND_HI = 24'h002028;

    typedef logic [1:0] prio_t;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_PRIO_LO,
        REG_PRIO_HI,
        REG_EN_LO,
        REG_EN_HI,
        REG_PEND_LO,
        REG_PEND_HI
    } reg_sel_t;

    function automatic reg_sel_t decode_addr(input logic [23:0] addr);
        reg_sel_t sel;
        case (addr)
            ADDR_PRIO_LO: sel = REG_PRIO_LO;
            ADDR_PRIO_HI: sel = REG_PRIO_HI;
            ADDR_EN_LO:   sel = REG_EN_LO;
            ADDR_EN_HI:   sel = REG_EN_HI;
            ADDR_PEND_LO: sel = REG_PEND_LO;
            ADDR_PEND_HI: sel = REG_PEND_HI;
            default:      sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/irq_controller_arbiter.sv
// Combinational priority selector: highest level wins, ties go to the
// lowest source index.
module irq_arbiter
    import pm_irq_pkg::*;
(
    input  logic [15:0]        eligible,
    input  prio_t [15:0]       src_level,
    output logic               valid,
    output logic [3:0]         index,
    output prio_t              level
);

    always_comb begin
        valid = 1'b0;
        index = '0;
        level = '0;
        // Ascending scan with strict '>' keeps the lowest index on equal levels.
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (!valid || src_level[i] > level)) begin
                valid = 1'b1;
                index = 4'(i);
                level = src_level[i];
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: per-source pending/enable flags,
// per-group priority, registered request presentation with CPU acknowledge.
module irq_controller #(
    parameter int unsigned NUM_SRC = pm_irq_pkg::NUM_SRC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic [15:0] irq_in,
    input  logic [1:0]  cpu_mask,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [3:0]  irq_source,
    output logic [1:0]  irq_level
);
    import pm_irq_pkg::*;

    logic [15:0] prio_q, prio_d;
    logic [15:0] en_q, en_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] irq_prev_q, irq_prev_d;
    logic        arm_q, arm_d;
    logic        irq_req_q, irq_req_d;
    logic [3:0]  irq_source_q, irq_source_d;
    prio_t       irq_level_q, irq_level_d;

    reg_sel_t     sel;
    logic [15:0]  sw_clr;
    logic [15:0]  ack_clr;
    logic [15:0]  rise;
    logic         ack_take;
    logic [15:0]  eligible;
    prio_t [15:0] src_level;
    logic         arb_valid;
    logic [3:0]   arb_index;
    prio_t        arb_level;

    // Reads have no side effects, so the strobe is not needed by the logic.
    logic unused_bus_read;
    assign unused_bus_read = bus_read;

    assign sel = decode_addr(bus_address_in);

    always_comb begin
        prio_d = prio_q;
        en_d   = en_q;
        sw_clr = '0;
        if (bus_write) begin
            case (sel)
                REG_PRIO_LO: prio_d[7:0]  = bus_data_in;
                REG_PRIO_HI: prio_d[15:8] = bus_data_in;
                REG_EN_LO:   en_d[7:0]    = bus_data_in;
                REG_EN_HI:   en_d[15:8]   = bus_data_in;
                REG_PEND_LO: sw_clr[7:0]  = bus_data_in;
                REG_PEND_HI: sw_clr[15:8] = bus_data_in;
                default:     ;
            endcase
        end
    end

    // arm_q suppresses edge detection on the first edge after reset, so lines
    // already high during reset are absorbed into irq_prev_q without a flag.
    always_comb begin
        irq_prev_d = irq_in;
        arm_d      = 1'b1;
        rise       = arm_q ? (irq_in & ~irq_prev_q) : '0;
        ack_take   = irq_ack & irq_req_q;
        ack_clr    = '0;
        if (ack_take) begin
            ack_clr[irq_source_q] = 1'b1;
        end
        pend_d = (pend_q & ~(sw_clr | ack_clr)) | rise;
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_level[i] = prio_q[2*(i/2) +: 2];
            eligible[i]  = pend_q[i] & en_q[i] & (src_level[i] != '0)
                         & (src_level[i] > cpu_mask);
        end
    end

    irq_arbiter u_arbiter (
        .eligible  (eligible),
        .src_level (src_level),
        .valid     (arb_valid),
        .index     (arb_index),
        .level     (arb_level)
    );

    always_comb begin
        irq_req_d    = arb_valid & ~ack_take;
        irq_source_d = irq_req_d ? arb_index : '0;
        irq_level_d  = irq_req_d ? arb_level : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q       <= '0;
            en_q         <= '0;
            pend_q       <= '0;
            irq_prev_q   <= '0;
            arm_q        <= 1'b0;
            irq_req_q    <= 1'b0;
            irq_source_q <= '0;
            irq_level_q  <= '0;
        end else begin
            prio_q       <= prio_d;
            en_q         <= en_d;
            pend_q       <= pend_d;
            irq_prev_q   <= irq_prev_d;
            arm_q        <= arm_d;
            irq_req_q    <= irq_req_d;
            irq_source_q <= irq_source_d;
            irq_level_q  <= irq_level_d;
        end
    end

    always_comb begin
        bus_data_out = '0;
        case (sel)
            REG_PRIO_LO: bus_data_out = prio_q[7:0];
            REG_PRIO_HI: bus_data_out = prio_q[15:8];
            REG_EN_LO:   bus_data_out = en_q[7:0];
            REG_EN_HI:   bus_data_out = en_q[15:8];
            REG_PEND_LO: bus_data_out = pend_q[7:0];
            REG_PEND_HI: bus_data_out = pend_q[15:8];
            default:     bus_data_out = '0;
        endcase
    end

    assign irq_req    = irq_req_q;
    assign irq_source = irq_source_q;
    assign irq_level  = irq_level_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register table plus hand sequences for
// request/ack, tie-break, masking, preemption, set-over-clear and reset.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [15:0] irq_in;
    logic [1:0]  cpu_mask;
    logic        irq_ack;
    logic        irq_req;
    logic [3:0]  irq_source;
    logic [1:0]  irq_level;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        do_wr;
        logic [23:0] waddr;
        logic [7:0]  wdat;
        logic [23:0] raddr;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[11];

    irq_controller #(.NUM_SRC(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (addr),
        .bus_data_in    (wdata),
        .bus_data_out   (rdata),
        .irq_in         (irq_in),
        .cpu_mask       (cpu_mask),
        .irq_ack        (irq_ack),
        .irq_req        (irq_req),
        .irq_source     (irq_source),
        .irq_level      (irq_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic r, input logic [3:0] s, input logic [1:0] l);
        check(name, {25'd0, irq_req, irq_source, irq_level}, {25'd0, r, s, l});
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        bus_write = 1'b1;
        addr      = a;
        wdata     = d;
        step();
        bus_write = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [23:0] a, input logic [7:0] exp);
        bus_read = 1'b1;
        addr     = a;
        #1;
        check(name, {24'd0, rdata}, {24'd0, exp});
        bus_read = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic all_regs_zero(input string tag);
        rd_check({tag, "_prio_lo"}, 24'h002020, 8'h00);
        rd_check({tag, "_prio_hi"}, 24'h002021, 8'h00);
        rd_check({tag, "_en_lo"},   24'h002023, 8'h00);
        rd_check({tag, "_en_hi"},   24'h002024, 8'h00);
        rd_check({tag, "_pend_lo"}, 24'h002027, 8'h00);
        rd_check({tag, "_pend_hi"}, 24'h002028, 8'h00);
    endtask

    initial begin
        reset     = 1'b1;
        bus_write = 1'b0;
        bus_read  = 1'b0;
        addr      = '0;
        wdata     = '0;
        irq_in    = '0;
        cpu_mask  = '0;
        irq_ack   = 1'b0;

        vecs[0]  = '{1'b1, 24'h002020, 8'hE4, 24'h002020, 8'hE4};
        vecs[1]  = '{1'b1, 24'h002021, 8'h1B, 24'h002021, 8'h1B};
        vecs[2]  = '{1'b1, 24'h002023, 8'hA5, 24'h002023, 8'hA5};
        vecs[3]  = '{1'b1, 24'h002024, 8'h5A, 24'h002024, 8'h5A};
        vecs[4]  = '{1'b1, 24'h002022, 8'hFF, 24'h002022, 8'h00};
        vecs[5]  = '{1'b1, 24'h002027, 8'hFF, 24'h002027, 8'h00};
        vecs[6]  = '{1'b1, 24'h012020, 8'h00, 24'h002020, 8'hE4};
        vecs[7]  = '{1'b0, 24'h000000, 8'h00, 24'h002028, 8'h00};
        vecs[8]  = '{1'b1, 24'h002025, 8'h11, 24'h002025, 8'h00};
        vecs[9]  = '{1'b1, 24'h002020, 8'h00, 24'h002020, 8'h00};
        vecs[10] = '{1'b0, 24'h000000, 8'h00, 24'h002024, 8'h5A};

        step();
        step();
        reset = 1'b0;
        check_out("reset_out", 1'b0, 4'd0, 2'd0);
        all_regs_zero("reset");
        step();

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdat);
            rd_check($sformatf("regvec%0d", i), vecs[i].raddr, vecs[i].exp);
        end

        // Basic request and acknowledge.
        do_reset();
        wr(24'h002020, 8'h02);
        wr(24'h002023, 8'h01);
        irq_in = 16'h0001;
        step();
        irq_in = 16'h0000;
        check_out("basic_flag_cycle", 1'b0, 4'd0, 2'd0);
        rd_check("basic_pend_set", 24'h002027, 8'h01);
        step();
        check_out("basic_req", 1'b1, 4'd0, 2'd2);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check_out("basic_after_ack", 1'b0, 4'd0, 2'd0);
        rd_check("basic_pend_cleared", 24'h002027, 8'h00);
        step();
        check_out("basic_stays_idle", 1'b0, 4'd0, 2'd0);

        // Tie-break between sources 1 and 3 at equal priority.
        do_reset();
        wr(24'h002020, 8'h05);
        wr(24'h002023, 8'h0A);
        irq_in = 16'h000A;
        step();
        irq_in = 16'h0000;
        step();
        check_out("tie_first", 1'b1, 4'd1, 2'd1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check_out("tie_ack_gap", 1'b0, 4'd0, 2'd0);
        step();
        check_out("tie_second", 1'b1, 4'd3, 2'd1);
        rd_check("tie_pend", 24'h002027, 8'h08);

        // Masking by cpu_mask, and ack while idle is ignored.
        do_reset();
        wr(24'h002020, 8'h01);
        wr(24'h002023, 8'h01);
        cpu_mask = 2'd1;
        irq_in = 16'h0001;
        step();
        irq_in = 16'h0000;
        step();
        check_out("mask_blocked", 1'b0, 4'd0, 2'd0);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check_out("mask_still_blocked", 1'b0, 4'd0, 2'd0);
        rd_check("mask_idle_ack_noop", 24'h002027, 8'h01);
        cpu_mask = 2'd0;
        step();
        check_out("mask_released", 1'b1, 4'd0, 2'd1);
        cpu_mask = 2'd1;
        step();
        check_out("mask_raised_drops", 1'b0, 4'd0, 2'd0);
        cpu_mask = 2'd0;

        // Preemption by a higher-priority source, then clear and disable.
        do_reset();
        wr(24'h002020, 8'h10);
        wr(24'h002021, 8'h03);
        wr(24'h002023, 8'h10);
        wr(24'h002024, 8'h02);
        irq_in = 16'h0010;
        step();
        irq_in = 16'h0000;
        step();
        check_out("pre_src4", 1'b1, 4'd4, 2'd1);
        irq_in = 16'h0200;
        step();
        irq_in = 16'h0000;
        check_out("pre_flag_cycle", 1'b1, 4'd4, 2'd1);
        step();
        check_out("pre_src9", 1'b1, 4'd9, 2'd3);
        wr(24'h002028, 8'h02);
        check_out("pre_clear_edge", 1'b1, 4'd9, 2'd3);
        step();
        check_out("pre_back_to4", 1'b1, 4'd4, 2'd1);
        wr(24'h002023, 8'h00);
        step();
        check_out("pre_disabled", 1'b0, 4'd0, 2'd0);

        // Set wins over a same-cycle software clear.
        do_reset();
        irq_in    = 16'h0001;
        bus_write = 1'b1;
        addr      = 24'h002027;
        wdata     = 8'h01;
        step();
        bus_write = 1'b0;
        irq_in    = 16'h0000;
        rd_check("set_over_clear", 24'h002027, 8'h01);
        wr(24'h002027, 8'h01);
        rd_check("w1c_clears", 24'h002027, 8'h00);

        // Reset while a request is presented, with irq_in held high.
        do_reset();
        wr(24'h002020, 8'h02);
        wr(24'h002023, 8'h01);
        irq_in = 16'h0001;
        step();
        step();
        check_out("rst_mid_req", 1'b1, 4'd0, 2'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_out("rst_out_zero", 1'b0, 4'd0, 2'd0);
        all_regs_zero("rst_mid");
        step();
        step();
        rd_check("rst_held_line_no_flag", 24'h002027, 8'h00);
        irq_in = 16'h0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
